// File: rtl/lc3b_pipe_pkg.sv
// Shared types and constants for the LC-3b pipeline fetch stage.
package lc3b_pipe_pkg;

    localparam logic [15:0] LC3B_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        PCMUX_NONE   = 2'b00,
        PCMUX_TARGET = 2'b01,
        PCMUX_TRAP   = 2'b10
    } pcmux_e;

    typedef enum logic {
        FE_FETCH,
        FE_DRAIN
    } fe_state_e;

    typedef enum logic [1:0] {
        PCSEL_HOLD,
        PCSEL_INC,
        PCSEL_RTGT,
        PCSEL_PEND
    } pcsel_e;

    // The reserved encoding 11 behaves like "no redirect".
    function automatic logic is_redirect(input logic [1:0] pcmux);
        return (pcmux == PCMUX_TARGET) || (pcmux == PCMUX_TRAP);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and the I-cache.
interface fetch_stage_if;

    logic        ic_req;
    logic [15:0] ic_addr;
    logic [15:0] ic_rdata;
    logic        ic_ready;

    modport master (
        output ic_req,
        output ic_addr,
        input  ic_rdata,
        input  ic_ready
    );

    modport slave (
        input  ic_req,
        input  ic_addr,
        output ic_rdata,
        output ic_ready
    );

endinterface

// File: rtl/fetch_redirect_fsm.sv
// Tracks whether the in-flight I-memory access is stale after a redirect and
// chooses where the PC goes next.
module fetch_redirect_fsm
    import lc3b_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        redir,
    input  logic [15:0] rtgt,
    input  logic        ic_ready,
    input  logic        advance,
    output pcsel_e      pc_sel,
    output logic        discard,
    output logic [15:0] pend_pc
);

    fe_state_e state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FE_FETCH;
            pend_pc <= 16'h0000;
        end else begin
            case (state)
                FE_FETCH: begin
                    if (redir && !ic_ready) begin
                        pend_pc <= rtgt;
                        state   <= FE_DRAIN;
                    end
                end
                FE_DRAIN: begin
                    if (redir) pend_pc <= rtgt;
                    if (ic_ready) state <= FE_FETCH;
                end
                default: state <= FE_FETCH;
            endcase
        end
    end

    // While draining, a redirect arriving with the completing access is the newest and wins.
    always_comb begin
        pc_sel  = PCSEL_HOLD;
        discard = redir || (state == FE_DRAIN);
        if (state == FE_FETCH) begin
            if (redir) begin
                if (ic_ready) pc_sel = PCSEL_RTGT;
            end else if (ic_ready && advance) begin
                pc_sel = PCSEL_INC;
            end
        end else if (ic_ready) begin
            pc_sel = redir ? PCSEL_RTGT : PCSEL_PEND;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b FE stage: owns the PC, issues fetches and loads the FE->DE latches,
// honouring stalls and MEM-stage redirects.
module fetch_stage
    import lc3b_pipe_pkg::*;
#(
    parameter logic [15:0] RESET_PC = LC3B_RESET_PC
)
(
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master ic,
    input  logic          dep_stall,
    input  logic          mem_stall,
    input  logic          v_de_br_stall,
    input  logic          v_agex_br_stall,
    input  logic          v_mem_br_stall,
    input  logic [1:0]    mem_pcmux,
    input  logic [15:0]   target_pc,
    input  logic [15:0]   trap_pc,
    output logic [15:0]   de_npc,
    output logic [15:0]   de_ir,
    output logic          de_v
);

    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] rtgt;
    logic [15:0] pend_pc;
    logic        ld_de;
    logic        brs;
    logic        redir;
    logic        discard;
    pcsel_e      pc_sel;

    assign ld_de  = !(dep_stall || mem_stall);
    assign brs    = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
    assign redir  = is_redirect(mem_pcmux);
    assign rtgt   = ((mem_pcmux == PCMUX_TRAP) ? trap_pc : target_pc) & 16'hFFFE;
    assign pc_inc = pc + 16'd2;

    assign ic.ic_req  = !reset;
    assign ic.ic_addr = pc;

    fetch_redirect_fsm u_redirect_fsm (
        .clk      (clk),
        .reset    (reset),
        .redir    (redir),
        .rtgt     (rtgt),
        .ic_ready (ic.ic_ready),
        .advance  (ld_de && !brs),
        .pc_sel   (pc_sel),
        .discard  (discard),
        .pend_pc  (pend_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (pc_sel)
                PCSEL_INC:  pc <= pc_inc;
                PCSEL_RTGT: pc <= rtgt;
                PCSEL_PEND: pc <= pend_pc;
                default:    pc <= pc;
            endcase
        end
    end

    // The latch loads whenever the pipe is not stalled; only a clean, current fetch is marked valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            de_npc <= 16'h0000;
            de_ir  <= 16'h0000;
            de_v   <= 1'b0;
        end else if (ld_de) begin
            de_npc <= pc_inc;
            de_ir  <= ic.ic_rdata;
            de_v   <= ic.ic_ready && !brs && !discard;
        end
    end

    a_no_reserved_pcmux : assert property (@(posedge clk) disable iff (reset) mem_pcmux != 2'b11);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic compared against a cycle-level behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        dep_stall;
    logic        mem_stall;
    logic        v_de_br_stall;
    logic        v_agex_br_stall;
    logic        v_mem_br_stall;
    logic [1:0]  mem_pcmux;
    logic [15:0] target_pc;
    logic [15:0] trap_pc;
    logic [15:0] de_npc;
    logic [15:0] de_ir;
    logic        de_v;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mPc;
    logic        mDraining;
    logic [15:0] mPending;
    logic [15:0] mNpc;
    logic [15:0] mIr;
    logic        mValid;

    fetch_stage_if icb();

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ic              (icb),
        .dep_stall       (dep_stall),
        .mem_stall       (mem_stall),
        .v_de_br_stall   (v_de_br_stall),
        .v_agex_br_stall (v_agex_br_stall),
        .v_mem_br_stall  (v_mem_br_stall),
        .mem_pcmux       (mem_pcmux),
        .target_pc       (target_pc),
        .trap_pc         (trap_pc),
        .de_npc          (de_npc),
        .de_ir           (de_ir),
        .de_v            (de_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of the fetch stage described by its rules rather than its structure.
    task automatic modelStep();
        logic        isRedirect;
        logic [15:0] redirectTo;
        logic        stalled;
        logic        branchShadow;
        logic [15:0] fetchedPc;
        if (reset) begin
            mPc = 16'h3000; mDraining = 1'b0; mPending = 16'h0000;
            mNpc = 16'h0000; mIr = 16'h0000; mValid = 1'b0;
            return;
        end
        isRedirect   = (mem_pcmux == 2'd1) || (mem_pcmux == 2'd2);
        redirectTo   = ((mem_pcmux == 2'd2) ? trap_pc : target_pc) & 16'hFFFE;
        stalled      = dep_stall || mem_stall;
        branchShadow = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
        fetchedPc    = mPc;
        if (!stalled) begin
            mIr    = icb.ic_rdata;
            mNpc   = 16'(fetchedPc + 16'd2);
            mValid = !mDraining && icb.ic_ready && !branchShadow && !isRedirect;
        end
        if (mDraining) begin
            if (isRedirect) mPending = redirectTo;
            if (icb.ic_ready) begin
                mPc       = mPending;
                mDraining = 1'b0;
            end
        end else if (isRedirect) begin
            if (icb.ic_ready) mPc = redirectTo;
            else begin
                mPending  = redirectTo;
                mDraining = 1'b1;
            end
        end else if (icb.ic_ready && !stalled && !branchShadow) begin
            mPc = 16'(fetchedPc + 16'd2);
        end
    endtask

    // Inputs are set by the caller before this runs; it advances one cycle and compares at the falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("ic_req",  {15'd0, icb.ic_req}, {15'd0, !reset});
        checkOutput("ic_addr", icb.ic_addr, mPc);
        checkOutput("de_v",    {15'd0, de_v}, {15'd0, mValid});
        checkOutput("de_npc",  de_npc, mNpc);
        checkOutput("de_ir",   de_ir, mIr);
    endtask

    task automatic idleInputs();
        dep_stall = 1'b0; mem_stall = 1'b0;
        v_de_br_stall = 1'b0; v_agex_br_stall = 1'b0; v_mem_br_stall = 1'b0;
        mem_pcmux = 2'b00; target_pc = 16'h0000; trap_pc = 16'h0000;
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;
        icb.ic_ready = 1'b0;
        icb.ic_rdata = 16'h0000;

        applyStimulus();
        applyStimulus();
        checkOutput("rst_req",  {15'd0, icb.ic_req}, 16'd0);
        checkOutput("rst_addr", icb.ic_addr, 16'h3000);
        checkOutput("rst_v",    {15'd0, de_v}, 16'd0);

        reset = 1'b0; icb.ic_ready = 1'b1; icb.ic_rdata = 16'h1234;
        applyStimulus();
        checkOutput("first_ir",   de_ir, 16'h1234);
        checkOutput("first_npc",  de_npc, 16'h3002);
        checkOutput("first_v",    {15'd0, de_v}, 16'd1);
        checkOutput("first_addr", icb.ic_addr, 16'h3002);

        icb.ic_ready = 1'b0;
        repeat (4) begin
            applyStimulus();
            checkOutput("miss_addr", icb.ic_addr, 16'h3002);
            checkOutput("miss_v",    {15'd0, de_v}, 16'd0);
        end
        icb.ic_ready = 1'b1; icb.ic_rdata = 16'hABCD;
        applyStimulus();
        checkOutput("hit_npc", de_npc, 16'h3004);
        checkOutput("hit_v",   {15'd0, de_v}, 16'd1);

        dep_stall = 1'b1; icb.ic_rdata = 16'h5555;
        repeat (2) begin
            applyStimulus();
            checkOutput("stall_ir",   de_ir, 16'hABCD);
            checkOutput("stall_addr", icb.ic_addr, 16'h3004);
        end
        dep_stall = 1'b0;
        applyStimulus();
        checkOutput("resume_addr", icb.ic_addr, 16'h3006);

        icb.ic_ready = 1'b0; mem_pcmux = 2'b10; trap_pc = 16'h0020;
        applyStimulus();
        checkOutput("drain_addr", icb.ic_addr, 16'h3006);
        mem_pcmux = 2'b00;
        applyStimulus();
        checkOutput("drain_hold", icb.ic_addr, 16'h3006);
        icb.ic_ready = 1'b1;
        applyStimulus();
        checkOutput("drain_v",    {15'd0, de_v}, 16'd0);
        checkOutput("trap_addr",  icb.ic_addr, 16'h0020);

        mem_pcmux = 2'b01; target_pc = 16'hFFFF;
        applyStimulus();
        checkOutput("tgt_addr", icb.ic_addr, 16'hFFFE);
        mem_pcmux = 2'b00;
        applyStimulus();
        checkOutput("wrap_npc",  de_npc, 16'h0000);
        checkOutput("wrap_addr", icb.ic_addr, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 63) == 0);
            icb.ic_ready    = ($urandom_range(0, 9) < 7);
            icb.ic_rdata    = 16'($urandom);
            dep_stall       = ($urandom_range(0, 9) == 0);
            mem_stall       = ($urandom_range(0, 9) == 0);
            v_de_br_stall   = ($urandom_range(0, 9) == 0);
            v_agex_br_stall = ($urandom_range(0, 15) == 0);
            v_mem_br_stall  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 9))
                0:       mem_pcmux = 2'b01;
                1:       mem_pcmux = 2'b10;
                default: mem_pcmux = 2'b00;
            endcase
            target_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
            trap_pc   = 16'($urandom);
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
